vending_controller_mp: RTL and testbench
========================================

# vending_controller_mp

Parametrised multi-product vending controller, the next generation of the single-product vending FSM. Supports N_ITEMS products with a runtime price table, per-item stock counters with restock, a saturation limit on balance, and serial coin-by-coin change return (largest coin first). It sits between the coin acceptor/keypad front end and the dispenser/change hopper actuators.

## Interface

Parameters:
- N_ITEMS, 4, number of products (≥2)
- BAL_W, 8, width of balance, prices and change remainder
- STOCK_W, 4, width of each per-item stock counter
- MAX_BAL, 99, highest balance accepted (must be < 2^BAL_W)
- INIT_STOCK, 5, stock value loaded into every item at reset

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- coin  in  2  00 none, 01 = 1, 10 = 2, 11 = 5
- sel_valid  in  1  purchase request strobe
- sel_idx  in  clog2(N_ITEMS)  product index, valid with sel_valid
- cancel  in  1  refund request
- price_flat  in  N_ITEMS*BAL_W  price of item i in bits [i*BAL_W +: BAL_W]
- restock_valid  in  1  restock strobe
- restock_idx  in  clog2(N_ITEMS)  item to restock
- restock_qty  in  STOCK_W  quantity to add
- balance  out  BAL_W  current credited balance
- dispense  out  1  one-cycle vend pulse
- dispense_idx  out  clog2(N_ITEMS)  item vended, valid with dispense
- change_valid  out  1  one change coin this cycle
- change_coin  out  2  coin ejected, same encoding as coin
- coin_reject  out  1  one-cycle pulse: coin not credited
- sold_out  out  1  one-cycle pulse: selected item has zero stock
- insufficient  out  1  one-cycle pulse: balance < price at selection
- busy  out  1  high in VEND and CHANGE

## Operation

- All outputs registered. Reset: state IDLE, balance 0, remainder 0, every stock = INIT_STOCK, all pulse outputs 0, change_coin 00, dispense_idx 0, busy 0.
- States: IDLE, VEND, CHANGE.
- IDLE, per-cycle priority: cancel > sel_valid > restock_valid > coin.
  - cancel: balance > 0 → remainder = balance, balance = 0, go CHANGE; balance 0 → no action.
  - sel_valid, sel_idx ≥ N_ITEMS: ignored. stock == 0 → sold_out pulse, stay. balance < price → insufficient pulse, stay. Otherwise latch idx and price, go VEND.
  - restock: stock += qty, saturating at 2^STOCK_W−1.
  - coin ≠ 00: credited if balance + value ≤ MAX_BAL, else coin_reject pulse and balance unchanged.
  - A coin arriving in the same cycle as an accepted cancel or select is rejected (coin_reject pulse). A restock in the same cycle as cancel/select is dropped.
- VEND (one cycle): dispense = 1, dispense_idx = latched idx, stock[idx] −1. remainder = balance − price, balance = 0. Next state CHANGE if remainder > 0, else IDLE.
- CHANGE: each cycle change_valid = 1 with change_coin = 11 if remainder ≥ 5, else 10 if ≥ 2, else 01; remainder −= value. Return to IDLE after the cycle in which remainder reaches 0.
- During busy: coins → coin_reject; sel_valid, cancel, restock ignored.
- Price 0 is legal: vend, full balance returned as change.

## Timing

- Coin sampled at edge t: balance or coin_reject visible in cycle t+1.
- Select at edge t (sufficient credit): dispense high in cycle t+1; first change coin in t+2; balance reads 0 from t+2.
- Cancel at edge t: balance 0 and first change coin in cycle t+1.
- Change of R takes floor(R/5) + greedy-remainder cycles; busy falls the cycle after the last change coin.
- Asynchronous reset mid-VEND or mid-CHANGE: immediate return to reset values; the pending remainder is discarded.

## Test plan

- Prices {5,7,10,3}: coins 5,5,2 (balance 12), select 1 → dispense idx 1 at t+1, one change coin 11, stock[1] 5→4, balance 0.
- Balance 14, select 0 (price 5) → change coins 11, 10, 10 on consecutive cycles, then busy low.
- Balance 8, cancel → change coins 11, 10, 01; no dispense.
- Stock[2] driven to 0 via five purchases; sixth select 2 → sold_out pulse, balance unchanged; restock 2 qty 3 → purchase succeeds.
- Balance 97, coin 5 → coin_reject, balance 97; coin 2 → balance 99; coin during CHANGE → coin_reject.
- Reset asserted mid-CHANGE with remainder 9 → all outputs to reset values immediately; stocks = INIT_STOCK.

Source files
------------

// File: rtl/vending_controller_mp.sv
// Multi-product vending controller: runtime price table, per-item stock with restock,
// saturating balance and greedy coin-by-coin change return.
module vending_controller_mp #(
  parameter  int N_ITEMS    = 4,
  parameter  int BAL_W      = 8,
  parameter  int STOCK_W    = 4,
  parameter  int MAX_BAL    = 99,
  parameter  int INIT_STOCK = 5,
  localparam int IDX_W      = $clog2(N_ITEMS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 coin,
  input  logic                       sel_valid,
  input  logic [IDX_W-1:0]           sel_idx,
  input  logic                       cancel,
  input  logic [N_ITEMS*BAL_W-1:0]   price_flat,
  input  logic                       restock_valid,
  input  logic [IDX_W-1:0]           restock_idx,
  input  logic [STOCK_W-1:0]         restock_qty,
  output logic [BAL_W-1:0]           balance,
  output logic                       dispense,
  output logic [IDX_W-1:0]           dispense_idx,
  output logic                       change_valid,
  output logic [1:0]                 change_coin,
  output logic                       coin_reject,
  output logic                       sold_out,
  output logic                       insufficient,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  state_t state, state_nxt;

  logic [BAL_W-1:0]   price [N_ITEMS];
  logic [STOCK_W-1:0] stock [N_ITEMS];
  logic [STOCK_W-1:0] stock_nxt [N_ITEMS];

  logic [BAL_W-1:0] remainder, remainder_nxt;
  logic [BAL_W-1:0] balance_nxt;
  logic [BAL_W-1:0] vend_price, vend_price_nxt;
  logic [IDX_W-1:0] vend_idx, vend_idx_nxt;
  logic [IDX_W-1:0] dispense_idx_nxt;
  logic             dispense_nxt, change_valid_nxt, coin_reject_nxt;
  logic             sold_out_nxt, insufficient_nxt;
  logic [1:0]       change_coin_nxt;

  logic [BAL_W:0]   coin_sum;
  logic [STOCK_W:0] restock_sum;
  logic [BAL_W-1:0] vend_rem;
  logic [1:0]       out_coin;
  logic             taken, sel_ok, restock_ok;

  for (genvar g = 0; g < N_ITEMS; g++) begin : g_price
    assign price[g] = price_flat[g*BAL_W +: BAL_W];
  end

  function automatic logic [BAL_W-1:0] coin_val(input logic [1:0] code);
    case (code)
      2'b01:   return BAL_W'(1);
      2'b10:   return BAL_W'(2);
      2'b11:   return BAL_W'(5);
      default: return BAL_W'(0);
    endcase
  endfunction

  // Largest coin that does not exceed the amount still owed.
  function automatic logic [1:0] pick_coin(input logic [BAL_W-1:0] amt);
    if (amt >= BAL_W'(5))      return 2'b11;
    else if (amt >= BAL_W'(2)) return 2'b10;
    else                       return 2'b01;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      balance      <= '0;
      remainder    <= '0;
      vend_price   <= '0;
      vend_idx     <= '0;
      dispense     <= 1'b0;
      dispense_idx <= '0;
      change_valid <= 1'b0;
      change_coin  <= 2'b00;
      coin_reject  <= 1'b0;
      sold_out     <= 1'b0;
      insufficient <= 1'b0;
      busy         <= 1'b0;
      for (int i = 0; i < N_ITEMS; i++) stock[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      state        <= state_nxt;
      balance      <= balance_nxt;
      remainder    <= remainder_nxt;
      vend_price   <= vend_price_nxt;
      vend_idx     <= vend_idx_nxt;
      dispense     <= dispense_nxt;
      dispense_idx <= dispense_idx_nxt;
      change_valid <= change_valid_nxt;
      change_coin  <= change_coin_nxt;
      coin_reject  <= coin_reject_nxt;
      sold_out     <= sold_out_nxt;
      insufficient <= insufficient_nxt;
      busy         <= (state_nxt != IDLE);
      stock        <= stock_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    balance_nxt      = balance;
    remainder_nxt    = remainder;
    vend_price_nxt   = vend_price;
    vend_idx_nxt     = vend_idx;
    stock_nxt        = stock;
    dispense_nxt     = 1'b0;
    dispense_idx_nxt = dispense_idx;
    change_valid_nxt = 1'b0;
    change_coin_nxt  = 2'b00;
    coin_reject_nxt  = 1'b0;
    sold_out_nxt     = 1'b0;
    insufficient_nxt = 1'b0;
    taken            = 1'b0;
    out_coin         = 2'b00;
    vend_rem         = balance - vend_price;
    coin_sum         = {1'b0, balance} + {1'b0, coin_val(coin)};
    restock_sum      = {1'b0, stock[restock_idx]} + {1'b0, restock_qty};
    sel_ok           = ({1'b0, sel_idx} < (IDX_W+1)'(N_ITEMS));
    restock_ok       = ({1'b0, restock_idx} < (IDX_W+1)'(N_ITEMS));

    case (state)
      IDLE: begin
        // A cancel, even with nothing to refund, claims the cycle over a selection.
        if (cancel) begin
          if (balance != '0) begin
            taken            = 1'b1;
            out_coin         = pick_coin(balance);
            balance_nxt      = '0;
            remainder_nxt    = balance - coin_val(out_coin);
            change_valid_nxt = 1'b1;
            change_coin_nxt  = out_coin;
            state_nxt        = CHANGE;
          end
        end else if (sel_valid && sel_ok) begin
          if (stock[sel_idx] == '0) begin
            sold_out_nxt = 1'b1;
          end else if (balance < price[sel_idx]) begin
            insufficient_nxt = 1'b1;
          end else begin
            taken            = 1'b1;
            vend_idx_nxt     = sel_idx;
            vend_price_nxt   = price[sel_idx];
            dispense_nxt     = 1'b1;
            dispense_idx_nxt = sel_idx;
            state_nxt        = VEND;
          end
        end

        if (!taken && restock_valid && restock_ok) begin
          stock_nxt[restock_idx] = restock_sum[STOCK_W] ? '1 : restock_sum[STOCK_W-1:0];
        end

        if (coin != 2'b00) begin
          if (!taken && (coin_sum <= (BAL_W+1)'(MAX_BAL))) balance_nxt = coin_sum[BAL_W-1:0];
          else                                            coin_reject_nxt = 1'b1;
        end
      end

      VEND: begin
        coin_reject_nxt        = (coin != 2'b00);
        stock_nxt[vend_idx]    = stock[vend_idx] - STOCK_W'(1);
        balance_nxt            = '0;
        if (vend_rem != '0) begin
          out_coin         = pick_coin(vend_rem);
          remainder_nxt    = vend_rem - coin_val(out_coin);
          change_valid_nxt = 1'b1;
          change_coin_nxt  = out_coin;
          state_nxt        = CHANGE;
        end else begin
          remainder_nxt = '0;
          state_nxt     = IDLE;
        end
      end

      CHANGE: begin
        coin_reject_nxt = (coin != 2'b00);
        if (remainder != '0) begin
          out_coin         = pick_coin(remainder);
          remainder_nxt    = remainder - coin_val(out_coin);
          change_valid_nxt = 1'b1;
          change_coin_nxt  = out_coin;
        end else begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vending_controller_mp.sv
// Directed bench for vending_controller_mp: a vector table for the basic flows plus
// hand-written sequences for saturation, stock depletion/restock and mid-change reset.
module tb_vending_controller_mp;

  logic        clk;
  logic        reset;
  logic [1:0]  coin;
  logic        sel_valid;
  logic [1:0]  sel_idx;
  logic        cancel;
  logic [31:0] price_flat;
  logic        restock_valid;
  logic [1:0]  restock_idx;
  logic [3:0]  restock_qty;
  logic [7:0]  balance;
  logic        dispense;
  logic [1:0]  dispense_idx;
  logic        change_valid;
  logic [1:0]  change_coin;
  logic        coin_reject;
  logic        sold_out;
  logic        insufficient;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_didx;

  typedef struct {
    logic [1:0] coin;
    logic       sel_valid;
    logic [1:0] sel_idx;
    logic       cancel;
    logic [7:0] bal;
    logic       disp;
    logic [1:0] didx;
    logic       cv;
    logic [1:0] cc;
    logic       rej;
    logic       so;
    logic       ins;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  vending_controller_mp dut (
    .clk(clk), .reset(reset), .coin(coin), .sel_valid(sel_valid), .sel_idx(sel_idx),
    .cancel(cancel), .price_flat(price_flat), .restock_valid(restock_valid),
    .restock_idx(restock_idx), .restock_qty(restock_qty), .balance(balance),
    .dispense(dispense), .dispense_idx(dispense_idx), .change_valid(change_valid),
    .change_coin(change_coin), .coin_reject(coin_reject), .sold_out(sold_out),
    .insufficient(insufficient), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mk(input logic [1:0] c, input logic sv, input logic [1:0] si,
                              input logic cn, input logic [7:0] b, input logic d,
                              input logic [1:0] di, input logic cv, input logic [1:0] cc,
                              input logic rj, input logic so, input logic ins, input logic bz);
    vec_t v;
    v.coin = c; v.sel_valid = sv; v.sel_idx = si; v.cancel = cn;
    v.bal = b; v.disp = d; v.didx = di; v.cv = cv; v.cc = cc;
    v.rej = rj; v.so = so; v.ins = ins; v.busy = bz;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [7:0] e_bal, input logic e_disp,
                            input logic [1:0] e_didx, input logic e_cv, input logic [1:0] e_cc,
                            input logic e_rej, input logic e_so, input logic e_ins,
                            input logic e_busy);
    chk({tag, ".balance"},      32'(balance),      32'(e_bal));
    chk({tag, ".dispense"},     32'(dispense),     32'(e_disp));
    chk({tag, ".dispense_idx"}, 32'(dispense_idx), 32'(e_didx));
    chk({tag, ".change_valid"}, 32'(change_valid), 32'(e_cv));
    chk({tag, ".change_coin"},  32'(change_coin),  32'(e_cc));
    chk({tag, ".coin_reject"},  32'(coin_reject),  32'(e_rej));
    chk({tag, ".sold_out"},     32'(sold_out),     32'(e_so));
    chk({tag, ".insufficient"}, 32'(insufficient), 32'(e_ins));
    chk({tag, ".busy"},         32'(busy),         32'(e_busy));
  endtask

  // One clock of stimulus; outputs are sampled 1 ns after the edge.
  task automatic drive(input logic [1:0] c, input logic sv, input logic [1:0] si,
                       input logic cn, input logic rv, input logic [1:0] ri,
                       input logic [3:0] rq);
    coin = c; sel_valid = sv; sel_idx = si; cancel = cn;
    restock_valid = rv; restock_idx = ri; restock_qty = rq;
    @(posedge clk);
    #1;
    coin = 2'b00; sel_valid = 1'b0; sel_idx = 2'd0; cancel = 1'b0;
    restock_valid = 1'b0; restock_idx = 2'd0; restock_qty = 4'd0;
  endtask

  task automatic applyStimulus(input vec_t v);
    drive(v.coin, v.sel_valid, v.sel_idx, v.cancel, 1'b0, 2'd0, 4'd0);
  endtask

  task automatic checkOutput(input vec_t v, input int n);
    expect_all($sformatf("vec%0d", n), v.bal, v.disp, v.didx, v.cv, v.cc,
               v.rej, v.so, v.ins, v.busy);
  endtask

  // Buy item 2 (price 10) starting from a zero balance.
  task automatic buy_item2(input string tag, input bit expect_ok);
    drive(2'b11, 0, 0, 0, 0, 0, 0);
    expect_all({tag, ".c1"}, 8'd5, 0, exp_didx, 0, 0, 0, 0, 0, 0);
    drive(2'b11, 0, 0, 0, 0, 0, 0);
    expect_all({tag, ".c2"}, 8'd10, 0, exp_didx, 0, 0, 0, 0, 0, 0);
    drive(2'b00, 1, 2'd2, 0, 0, 0, 0);
    if (expect_ok) begin
      exp_didx = 2'd2;
      expect_all({tag, ".sel"}, 8'd10, 1, exp_didx, 0, 0, 0, 0, 0, 1);
      drive(2'b00, 0, 0, 0, 0, 0, 0);
      expect_all({tag, ".done"}, 8'd0, 0, exp_didx, 0, 0, 0, 0, 0, 0);
    end else begin
      expect_all({tag, ".soldout"}, 8'd10, 0, exp_didx, 0, 0, 0, 1, 0, 0);
    end
  endtask

  initial begin
    price_flat = {8'd3, 8'd10, 8'd7, 8'd5};
    coin = 2'b00; sel_valid = 1'b0; sel_idx = 2'd0; cancel = 1'b0;
    restock_valid = 1'b0; restock_idx = 2'd0; restock_qty = 4'd0;
    exp_didx = 2'd0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_all("reset", 8'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Buy item 1 with 12 (coin landing with the select is rejected), one 5-coin change.
    vecs.push_back(mk(2'b11, 0, 0, 0,  8'd5, 0, 0, 0, 0,     0, 0, 0, 0));
    vecs.push_back(mk(2'b11, 0, 0, 0, 8'd10, 0, 0, 0, 0,     0, 0, 0, 0));
    vecs.push_back(mk(2'b10, 0, 0, 0, 8'd12, 0, 0, 0, 0,     0, 0, 0, 0));
    vecs.push_back(mk(2'b01, 1, 1, 0, 8'd12, 1, 1, 0, 0,     1, 0, 0, 1));
    vecs.push_back(mk(2'b00, 0, 0, 0,  8'd0, 0, 1, 1, 2'b11, 0, 0, 0, 1));
    vecs.push_back(mk(2'b00, 0, 0, 0,  8'd0, 0, 1, 0, 0,     0, 0, 0, 0));
    // Balance 14, item 0: change 5,2,2; coin and select during change are refused.
    vecs.push_back(mk(2'b11, 0, 0, 0,  8'd5, 0, 1, 0, 0,     0, 0, 0, 0));
    vecs.push_back(mk(2'b11, 0, 0, 0, 8'd10, 0, 1, 0, 0,     0, 0, 0, 0));
    vecs.push_back(mk(2'b10, 0, 0, 0, 8'd12, 0, 1, 0, 0,     0, 0, 0, 0));
    vecs.push_back(mk(2'b10, 0, 0, 0, 8'd14, 0, 1, 0, 0,     0, 0, 0, 0));
    vecs.push_back(mk(2'b00, 1, 0, 0, 8'd14, 1, 0, 0, 0,     0, 0, 0, 1));
    vecs.push_back(mk(2'b00, 0, 0, 0,  8'd0, 0, 0, 1, 2'b11, 0, 0, 0, 1));
    vecs.push_back(mk(2'b01, 0, 0, 0,  8'd0, 0, 0, 1, 2'b10, 1, 0, 0, 1));
    vecs.push_back(mk(2'b00, 1, 3, 0,  8'd0, 0, 0, 1, 2'b10, 0, 0, 0, 1));
    vecs.push_back(mk(2'b00, 0, 0, 0,  8'd0, 0, 0, 0, 0,     0, 0, 0, 0));
    // Balance 8 cancelled: 5,2,1; then insufficient, small refund, empty cancel.
    vecs.push_back(mk(2'b11, 0, 0, 0,  8'd5, 0, 0, 0, 0,     0, 0, 0, 0));
    vecs.push_back(mk(2'b10, 0, 0, 0,  8'd7, 0, 0, 0, 0,     0, 0, 0, 0));
    vecs.push_back(mk(2'b01, 0, 0, 0,  8'd8, 0, 0, 0, 0,     0, 0, 0, 0));
    vecs.push_back(mk(2'b00, 0, 0, 1,  8'd0, 0, 0, 1, 2'b11, 0, 0, 0, 1));
    vecs.push_back(mk(2'b00, 0, 0, 0,  8'd0, 0, 0, 1, 2'b10, 0, 0, 0, 1));
    vecs.push_back(mk(2'b00, 0, 0, 0,  8'd0, 0, 0, 1, 2'b01, 0, 0, 0, 1));
    vecs.push_back(mk(2'b00, 0, 0, 0,  8'd0, 0, 0, 0, 0,     0, 0, 0, 0));
    vecs.push_back(mk(2'b01, 0, 0, 0,  8'd1, 0, 0, 0, 0,     0, 0, 0, 0));
    vecs.push_back(mk(2'b00, 1, 3, 0,  8'd1, 0, 0, 0, 0,     0, 0, 1, 0));
    vecs.push_back(mk(2'b00, 0, 0, 1,  8'd0, 0, 0, 1, 2'b01, 0, 0, 0, 1));
    vecs.push_back(mk(2'b00, 0, 0, 0,  8'd0, 0, 0, 0, 0,     0, 0, 0, 0));
    vecs.push_back(mk(2'b00, 0, 0, 1,  8'd0, 0, 0, 0, 0,     0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end
    exp_didx = 2'd0;

    // Saturation at 99, then a 99 refund with a coin pushed in mid-change.
    for (int i = 1; i <= 19; i++) begin
      drive(2'b11, 0, 0, 0, 0, 0, 0);
      expect_all($sformatf("fill%0d", i), 8'(5 * i), 0, exp_didx, 0, 0, 0, 0, 0, 0);
    end
    drive(2'b10, 0, 0, 0, 0, 0, 0);
    expect_all("sat97", 8'd97, 0, exp_didx, 0, 0, 0, 0, 0, 0);
    drive(2'b11, 0, 0, 0, 0, 0, 0);
    expect_all("sat_rej5", 8'd97, 0, exp_didx, 0, 0, 1, 0, 0, 0);
    drive(2'b10, 0, 0, 0, 0, 0, 0);
    expect_all("sat99", 8'd99, 0, exp_didx, 0, 0, 0, 0, 0, 0);
    drive(2'b01, 0, 0, 0, 0, 0, 0);
    expect_all("sat_rej1", 8'd99, 0, exp_didx, 0, 0, 1, 0, 0, 0);
    drive(2'b00, 0, 0, 1, 0, 0, 0);
    expect_all("ref99_0", 8'd0, 0, exp_didx, 1, 2'b11, 0, 0, 0, 1);
    for (int i = 1; i <= 18; i++) begin
      drive((i == 7) ? 2'b11 : 2'b00, 0, 0, 0, 0, 0, 0);
      expect_all($sformatf("ref99_%0d", i), 8'd0, 0, exp_didx, 1, 2'b11,
                 (i == 7) ? 1'b1 : 1'b0, 0, 0, 1);
    end
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    expect_all("ref99_19", 8'd0, 0, exp_didx, 1, 2'b10, 0, 0, 0, 1);
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    expect_all("ref99_20", 8'd0, 0, exp_didx, 1, 2'b10, 0, 0, 0, 1);
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    expect_all("ref99_end", 8'd0, 0, exp_didx, 0, 0, 0, 0, 0, 0);

    // Deplete item 2, hit sold_out, restock 3 and buy again.
    for (int i = 0; i < 5; i++) buy_item2($sformatf("buy%0d", i), 1'b1);
    buy_item2("buy5", 1'b0);
    drive(2'b00, 0, 0, 0, 1, 2'd2, 4'd3);
    expect_all("restock", 8'd10, 0, exp_didx, 0, 0, 0, 0, 0, 0);
    drive(2'b00, 1, 2'd2, 0, 0, 0, 0);
    expect_all("rebuy.sel", 8'd10, 1, 2'd2, 0, 0, 0, 0, 0, 1);
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    expect_all("rebuy.done", 8'd0, 0, 2'd2, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of returning 9 change.
    drive(2'b11, 0, 0, 0, 0, 0, 0);
    drive(2'b11, 0, 0, 0, 0, 0, 0);
    drive(2'b10, 0, 0, 0, 0, 0, 0);
    drive(2'b10, 0, 0, 0, 0, 0, 0);
    expect_all("rst.bal14", 8'd14, 0, 2'd2, 0, 0, 0, 0, 0, 0);
    drive(2'b00, 1, 2'd0, 0, 0, 0, 0);
    expect_all("rst.sel", 8'd14, 1, 2'd0, 0, 0, 0, 0, 0, 1);
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    expect_all("rst.chg", 8'd0, 0, 2'd0, 1, 2'b11, 0, 0, 0, 1);
    #2 reset = 1'b1;
    #1;
    expect_all("rst.async", 8'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    expect_all("rst.after", 8'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    exp_didx = 2'd0;

    // Stock of item 2 must be back to five.
    for (int i = 0; i < 5; i++) buy_item2($sformatf("rbuy%0d", i), 1'b1);
    buy_item2("rbuy5", 1'b0);
    drive(2'b00, 0, 0, 1, 0, 0, 0);
    expect_all("rfund0", 8'd0, 0, 2'd2, 1, 2'b11, 0, 0, 0, 1);
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    expect_all("rfund1", 8'd0, 0, 2'd2, 1, 2'b11, 0, 0, 0, 1);
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    expect_all("rfund2", 8'd0, 0, 2'd2, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
